// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   - mdu_state_e     : hazard-controller FSM states (run / multiply-divide busy)
//   - REG_ZERO        : architectural $zero register index
//   - *_DEFAULT       : default parameter values for pipe_hazard_ctrl
package mips_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MDU_LAT_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT   = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-high reset.
//   i_clk   : clock, rising edge
//   i_rst   : synchronous reset, clears the count
//   i_inc   : count one event this cycle
//   o_value : registered count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_value;
  logic             w_full;

  assign w_full  = &r_value;
  assign o_value = r_value;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_inc && !w_full) begin
      r_value <= r_value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage MIPS pipeline.
// Each cycle decides whether PC, IF/ID and ID/EX advance, hold or take a bubble:
// taken-branch flush (highest), multiply/divide sequencing, then load-use stall.
// Control outputs are Mealy (combinational from state and inputs).
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_id_rs, i_id_rt         : source fields of the instruction in ID
//   i_id_uses_rt             : ID instruction reads rt
//   i_idex_mem_read          : instruction in EX is a load
//   i_idex_rt                : load destination in EX
//   i_ex_mdu_start           : EX holds a mult/div (level)
//   i_mem_branch_taken       : branch in MEM resolved taken
//   o_pc_write, o_ifid_write, o_idex_write : register enables
//   o_ifid_flush, o_idex_bubble, o_exmem_bubble : NOP / control-zero insertion
//   o_mdu_busy, o_mdu_result_valid : MDU sequencing status
//   o_stall_count, o_flush_count   : saturating performance counters
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_idex_mem_read,
  input  logic [4:0]       i_idex_rt,
  input  logic             i_ex_mdu_start,
  input  logic             i_mem_branch_taken,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_write,
  output logic             o_idex_bubble,
  output logic             o_exmem_bubble,
  output logic             o_mdu_busy,
  output logic             o_mdu_result_valid,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam int unsigned CNT_BITS = $clog2(MDU_LAT);
  // The start cycle itself is one stall, so BUSY counts down from MDU_LAT-2.
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MDU_LAT - 2);

  mdu_state_e          r_state;
  mdu_state_e          w_state_d;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_d;

  logic w_load_use;
  logic w_flush_inc;
  logic w_stall_inc;

  assign w_load_use = i_idex_mem_read && (i_idex_rt != REG_ZERO) &&
                      ((i_idex_rt == i_id_rs) || (i_id_uses_rt && (i_idex_rt == i_id_rt)));

  always_comb begin
    o_pc_write         = 1'b1;
    o_ifid_write       = 1'b1;
    o_ifid_flush       = 1'b0;
    o_idex_write       = 1'b1;
    o_idex_bubble      = 1'b0;
    o_exmem_bubble     = 1'b0;
    o_mdu_result_valid = 1'b0;
    w_state_d          = r_state;
    w_cnt_d            = r_cnt;
    w_flush_inc        = 1'b0;

    // A reset cycle presents plain RUN defaults regardless of inputs.
    if (!i_rst) begin
      if (i_mem_branch_taken) begin
        // Younger stages, including any mult/div in EX, are squashed.
        o_ifid_flush   = 1'b1;
        o_idex_bubble  = 1'b1;
        o_exmem_bubble = 1'b1;
        w_state_d      = ST_RUN;
        w_cnt_d        = '0;
        w_flush_inc    = 1'b1;
      end else if (r_state == ST_BUSY) begin
        if (r_cnt != '0) begin
          o_pc_write     = 1'b0;
          o_ifid_write   = 1'b0;
          o_idex_write   = 1'b0;
          o_exmem_bubble = 1'b1;
          w_cnt_d        = r_cnt - CNT_BITS'(1);
        end else begin
          o_mdu_result_valid = 1'b1;
          w_state_d          = ST_RUN;
        end
      end else if (i_ex_mdu_start) begin
        o_pc_write     = 1'b0;
        o_ifid_write   = 1'b0;
        o_idex_write   = 1'b0;
        o_exmem_bubble = 1'b1;
        w_cnt_d        = CNT_LOAD;
        w_state_d      = ST_BUSY;
      end else if (w_load_use) begin
        // Hold the consumer in ID, let a bubble enter EX behind the load.
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b1;
      end
    end
  end

  assign o_mdu_busy  = (r_state == ST_BUSY) && !i_rst;
  assign w_stall_inc = !o_pc_write;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_stall_inc),
    .o_value(o_stall_count)
  );

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_flush_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_flush_inc),
    .o_value(o_flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: instance A (MDU_LAT=4, CNT_W=3) and instance B
// (MDU_LAT=2, CNT_W=32) share one stimulus. A directed table with hand-derived
// expectations runs on A, then random stimulus; every cycle both instances are
// also compared against a cycle-indexed behavioural model.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       mr;
    logic [4:0] xrt;
    logic       st;
    logic       br;
    logic [7:0] exp;   // {pc,ifid_w,ifid_fl,idex_w,idex_bub,exmem_bub,busy,valid}
    int         es;    // stall_count seen this cycle
    int         ef;    // flush_count seen this cycle
  } vec_t;

  localparam logic [7:0] O_DEF = 8'hD0;
  localparam logic [7:0] O_LU  = 8'h18;
  localparam logic [7:0] O_MS  = 8'h04;
  localparam logic [7:0] O_MB  = 8'h06;
  localparam logic [7:0] O_REL = 8'hD3;
  localparam logic [7:0] O_FL  = 8'hFC;
  localparam logic [7:0] O_FLB = 8'hFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, uses, mr, st, br;
  logic [4:0] rs, rt, xrt;

  logic [7:0]  oa, ob;
  logic [2:0]  sa, fa;
  logic [31:0] sb, fb;

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(3)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rt(uses),
    .i_idex_mem_read(mr), .i_idex_rt(xrt), .i_ex_mdu_start(st), .i_mem_branch_taken(br),
    .o_pc_write(oa[7]), .o_ifid_write(oa[6]), .o_ifid_flush(oa[5]), .o_idex_write(oa[4]),
    .o_idex_bubble(oa[3]), .o_exmem_bubble(oa[2]), .o_mdu_busy(oa[1]),
    .o_mdu_result_valid(oa[0]), .o_stall_count(sa), .o_flush_count(fa)
  );

  pipe_hazard_ctrl #(.MDU_LAT(2), .CNT_W(32)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rt(uses),
    .i_idex_mem_read(mr), .i_idex_rt(xrt), .i_ex_mdu_start(st), .i_mem_branch_taken(br),
    .o_pc_write(ob[7]), .o_ifid_write(ob[6]), .o_ifid_flush(ob[5]), .o_idex_write(ob[4]),
    .o_idex_bubble(ob[3]), .o_exmem_bubble(ob[2]), .o_mdu_busy(ob[1]),
    .o_mdu_result_valid(ob[0]), .o_stall_count(sb), .o_flush_count(fb)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: an MDU op accepted at cycle t0 stalls cycles t0..t0+lat-2 and
  // releases at t0+lat-1; counts are plain integers clamped to the maximum.
  int    m_lat[2]  = '{4, 2};
  longint m_max[2] = '{7, 64'hFFFF_FFFF};
  bit    m_act[2], n_act[2];
  int    m_t0[2],  n_t0[2];
  longint m_s[2], n_s[2], m_f[2], n_f[2];

  function automatic longint sat_inc(longint v, longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic logic [7:0] model_eval(int k);
    logic pc = 1, ifw = 1, fl = 0, idw = 1, bub = 0, exb = 0, busy = 0, val = 0;
    logic lu;
    lu = mr && (xrt != 0) && ((xrt == rs) || (uses && (xrt == rt)));
    n_act[k] = m_act[k];
    n_t0[k]  = m_t0[k];
    n_f[k]   = m_f[k];
    if (rst) begin
      n_act[k] = 0; n_s[k] = 0; n_f[k] = 0;
      return 8'hD0;
    end
    busy = m_act[k];
    if (br) begin
      fl = 1; bub = 1; exb = 1;
      n_act[k] = 0;
      n_f[k] = sat_inc(m_f[k], m_max[k]);
    end else if (m_act[k]) begin
      if (cyc <= m_t0[k] + m_lat[k] - 2) begin
        pc = 0; ifw = 0; idw = 0; exb = 1;
      end else begin
        val = 1; n_act[k] = 0;
      end
    end else if (st) begin
      pc = 0; ifw = 0; idw = 0; exb = 1;
      n_act[k] = 1; n_t0[k] = cyc;
    end else if (lu) begin
      pc = 0; ifw = 0; bub = 1;
    end
    n_s[k] = pc ? m_s[k] : sat_inc(m_s[k], m_max[k]);
    return {pc, ifw, fl, idw, bub, exb, busy, val};
  endfunction

  task automatic check(string name, longint act, longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic run_cycle(vec_t v, bit hand);
    logic [7:0] ea, eb;
    rst = v.rst; rs = v.rs; rt = v.rt; uses = v.uses;
    mr = v.mr; xrt = v.xrt; st = v.st; br = v.br;
    #3;
    ea = model_eval(0);
    eb = model_eval(1);
    check("model_out_a", oa, ea);
    check("model_out_b", ob, eb);
    check("model_stall_a", sa, m_s[0]);
    check("model_flush_a", fa, m_f[0]);
    check("model_stall_b", sb, m_s[1]);
    check("model_flush_b", fb, m_f[1]);
    if (hand) begin
      check("table_out", oa, v.exp);
      check("table_stall", sa, v.es);
      check("table_flush", fa, v.ef);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = n_act[k]; m_t0[k] = n_t0[k]; m_s[k] = n_s[k]; m_f[k] = n_f[k];
    end
    cyc++;
  endtask

  function automatic vec_t mk(logic r, logic [4:0] a, logic [4:0] b, logic u, logic m,
                              logic [4:0] x, logic s, logic t, logic [7:0] e, int es, int ef);
    vec_t v;
    v.rst = r; v.rs = a; v.rt = b; v.uses = u; v.mr = m; v.xrt = x;
    v.st = s; v.br = t; v.exp = e; v.es = es; v.ef = ef;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    // Directed table for instance A (MDU_LAT=4, CNT_W=3).
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, 0));
    tbl.push_back(mk(0, 8, 0, 0, 1, 8, 0, 0, O_LU,  0, 0));   // load-use on rs
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, O_DEF, 1, 0));   // $zero never hazards
    tbl.push_back(mk(0, 3, 8, 0, 1, 8, 0, 0, O_DEF, 1, 0));   // rt not a source
    tbl.push_back(mk(0, 3, 8, 1, 1, 8, 0, 0, O_LU,  1, 0));   // rt is a source
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_DEF, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_MS,  0, 0));   // MDU at T
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_MB,  1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_MB,  2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_REL, 3, 0));   // T+3 release
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_DEF, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_MS,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, O_FLB, 1, 0));   // branch mid-BUSY
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 1, 1));   // RUN, no result
    tbl.push_back(mk(0, 8, 0, 0, 1, 8, 0, 1, O_FL,  1, 1));   // branch beats load-use
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, O_FL,  1, 2));   // branch beats MDU start
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 1, 3));
    for (int i = 0; i < 10; i++)                              // saturate at 7
      tbl.push_back(mk(0, 9, 0, 0, 1, 9, 0, 0, O_LU, (i + 1 > 7) ? 7 : i + 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 7, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_MS,  7, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_MB,  7, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_DEF, 7, 3));   // reset mid-BUSY
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, 0));

    // Power-up reset, unchecked: state is unknown until the first reset edge.
    rst = 1; rs = 0; rt = 0; uses = 0; mr = 0; xrt = 0; st = 0; br = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_t0[k] = 0; m_s[k] = 0; m_f[k] = 0;
    end

    foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

    // Random phase: small register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      v = mk($urandom_range(0, 63) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 8'h00, 0, 0);
      run_cycle(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard controller for the 5-stage MIPS pipeline.
- Decides each cycle whether the PC, IF/ID and ID/EX registers advance, hold or take a bubble.
- Detects load-use hazards, flushes the younger stages on a taken branch resolved in MEM, and sequences multi-cycle multiply/divide operations that occupy EX.
- Sits beside the pipeline registers; drives their enable and bubble inputs, and keeps saturating stall/flush performance counters.

## Interface
- MDU_LAT, 4, total cycles a mult/div occupies EX (legal range 2..16)
- CNT_W, 32, width of the performance counters
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- idex_MemRead  in  1  instruction in EX is a load
- idex_rt  in  5  destination rt of the instruction in EX
- ex_mdu_start  in  1  EX holds a mult/div op (level; stays high while held)
- mem_branch_taken  in  1  branch in MEM resolved taken
- pc_write  out  1  PC enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_write  out  1  ID/EX enable
- idex_bubble  out  1  ID/EX control fields (RegWrite, MemWrite, MemRead, Branch) load 0
- exmem_bubble  out  1  EX/MEM control fields load 0
- mdu_busy  out  1  FSM in BUSY
- mdu_result_valid  out  1  one-cycle pulse: mult/div result leaves EX this cycle
- stall_count  out  CNT_W  cycles with pc_write=0
- flush_count  out  CNT_W  taken-branch flush events

## Operation
- FSM states: RUN, BUSY. Counter `cnt` of width clog2(MDU_LAT).
- Default (RUN, no event): all write enables 1, all bubbles/flushes 0.
- Priority per cycle, highest first: branch flush > MDU sequencing > load-use.
- Branch flush, `mem_branch_taken`=1, any state:
  - ifid_flush=1, idex_bubble=1, exmem_bubble=1, all enables 1.
  - Next state RUN, cnt cleared, flush_count+1.
  - An MDU op in EX is younger than the branch and is cancelled: no mdu_result_valid.
- MDU sequencing:
  - In RUN with ex_mdu_start=1: stall this cycle, load cnt=MDU_LAT-2, go to BUSY.
  - In BUSY with cnt>0: stall, decrement.
  - In BUSY with cnt=0: release (enables 1), pulse mdu_result_valid, return to RUN.
  - ex_mdu_start is ignored in BUSY.
  - MDU stall: pc_write=ifid_write=idex_write=0, exmem_bubble=1.
- Load-use, RUN only, no higher-priority event:
  - Condition: idex_MemRead & idex_rt≠0 & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)).
  - Response: pc_write=ifid_write=0, idex_bubble=1, idex_write=1.
  - Condition clears naturally the next cycle; no state is kept.
- Counters:
  - stall_count increments on every cycle with pc_write=0.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Reset: state RUN, cnt=0, both counters 0. Outputs in a reset cycle equal the RUN defaults: enables 1, bubbles/flush 0, mdu_busy=0, mdu_result_valid=0.

## Timing
- Control outputs are combinational from current state and inputs (Mealy), so they take effect at the same rising edge as the hazard they answer.
- Load-use: exactly 1 stall cycle per hazard.
- MDU op first seen in EX at cycle T:
  - Stall cycles T..T+MDU_LAT-2 (MDU_LAT-1 cycles).
  - mdu_busy high T+1..T+MDU_LAT-1.
  - mdu_result_valid and advance at T+MDU_LAT-1.
- MDU_LAT=2: single stall cycle at T; BUSY lasts one cycle with cnt=0.
- Branch taken in the same cycle as load-use or MDU start: flush only, no stall, no BUSY entry.
- rst asserted mid-BUSY: next cycle is RUN; counters cleared; no mdu_result_valid pulse.
- Counters update on the edge ending the counted cycle and are registered outputs.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum (RUN, BUSY);
  - REG_ZERO = 5'd0;
  - the localparams for default MDU_LAT and CNT_W.
- One sub-module, `sat_counter` (width param, inc, rst, value). It is instantiated twice, for stall_count and flush_count.
- The FSM and hazard logic live in `pipe_hazard_ctrl`.
- This block requires write-enable inputs on the PC and on every pipeline register, including ID/EX.

## Test plan
- Reset, then idle 5 cycles -> all enables 1, bubbles 0, stall_count=0, flush_count=0.
- idex_MemRead=1, idex_rt=8, id_rs=8 -> one cycle pc_write=0, idex_bubble=1; stall_count=1. Same with idex_rt=0 -> no stall.
- id_rt=8, id_uses_rt=0, idex_rt=8 load -> no stall; with id_uses_rt=1 -> one stall.
- MDU_LAT=4, ex_mdu_start held from T -> stall T..T+2, mdu_result_valid at T+3, stall_count=3.
- Branch taken at T+1 during MDU busy -> ifid_flush, idex_bubble and exmem_bubble at T+1; RUN at T+2; no mdu_result_valid; flush_count=1. Branch together with a load-use hazard -> flush only, stall_count unchanged.
- CNT_W=3, 10 load-use stalls -> stall_count saturates at 7. rst mid-BUSY -> RUN and counters 0 next cycle.
